// File: rtl/interp_ctrl_pkg.sv
// Shared types and constants for the horizontal interpolation phase sequencer.
package interp_ctrl_pkg;

  localparam int unsigned RGBW = 16;

  typedef logic [RGBW-1:0] rgb565_t;

  typedef struct packed {
    rgb565_t prev;
    rgb565_t cur;
  } pix_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One source pixel per output pixel in Q1.fracw.
  function automatic int unsigned step_one(input int unsigned fracw);
    return 32'd1 << fracw;
  endfunction

endpackage

// File: rtl/interp_phase_ctrl_if.sv
// Source pixel stream (valid/ready) from the line buffer read side.
interface interp_phase_ctrl_if;
  import interp_ctrl_pkg::*;

  logic    in_valid;
  logic    in_ready;
  rgb565_t in_rgb;

  modport master (output in_valid, output in_rgb, input in_ready);
  modport slave  (input in_valid, input in_rgb, output in_ready);
endinterface

// File: rtl/interp_phase_acc.sv
// Phase accumulator: step latch with zero-step substitution, fractional
// accumulator and "next source pixel needed" flag.
module interp_phase_acc
  import interp_ctrl_pkg::*;
#(
  parameter int unsigned FRACW = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [FRACW:0]   step,
  input  logic             advance,
  input  logic             fill,
  input  logic             drop,
  output logic [FRACW-1:0] acc_frac,
  output logic             need,
  output logic             need_next_c
);

  localparam int unsigned SW = FRACW + 1;
  localparam logic [FRACW:0] STEP_ONE = SW'(step_one(FRACW));

  logic [FRACW:0]   step_q;
  logic [FRACW-1:0] acc_q;
  logic [FRACW:0]   acc_sum;
  logic             need_q;

  assign acc_sum = {1'b0, acc_q} + step_q;

  // A carry means the next output falls past the current source pixel.
  always_comb begin
    need_next_c = need_q;
    if (load || drop)
      need_next_c = 1'b0;
    else if (advance && acc_sum[FRACW])
      need_next_c = 1'b1;
    else if (fill)
      need_next_c = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= STEP_ONE;
      acc_q  <= '0;
      need_q <= 1'b0;
    end else begin
      need_q <= need_next_c;
      if (load) begin
        step_q <= (step == '0) ? STEP_ONE : step;
        acc_q  <= '0;
      end else if (advance) begin
        acc_q <= acc_sum[FRACW-1:0];
      end
    end
  end

  assign acc_frac = acc_q;
  assign need     = need_q;

endmodule

// File: rtl/interp_phase_ctrl.sv
// Horizontal phase sequencer feeding the RGB565 interpolator (upscale only).
// Optional JTFRAME_INTERP_STATS_EN builds a saturating underflow event counter.
module interp_phase_ctrl
  import interp_ctrl_pkg::*;
#(
  parameter int unsigned FRACW = 8,
  parameter int unsigned WW    = 12
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [FRACW:0]      step,
  input  logic [WW-1:0]       out_width,
  input  logic                ce_out,
  interp_phase_ctrl_if.slave  src,
  output rgb565_t             rgb_cur,
  output rgb565_t             rgb_prev,
  output logic [FRACW-1:0]    fraction,
  output logic                blank,
  output logic                line_done,
  output logic                underflow,
  output logic [7:0]          underflows
);

  state_t           state_q, state_d;
  logic             prime_q, prime_d;
  logic [WW-1:0]    width_q, width_d;
  logic [WW-1:0]    count_q, count_d;
  pix_pair_t        pair_q;
  pix_pair_t        out_d;
  logic [FRACW-1:0] frac_d;
  logic             blank_d, underflow_d, line_done_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, fill, emit, starve, drop;
  logic [FRACW-1:0] acc_frac;
  logic             need, need_next_c;

  // line_start wins over any handshake in the same cycle.
  assign accept = src.in_valid && in_ready_q && !line_start;
  assign fill   = accept && (state_q == RUN);

  interp_phase_acc #(.FRACW(FRACW)) u_acc (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .load        (line_start),
    .step        (step),
    .advance     (emit),
    .fill        (fill),
    .drop        (drop),
    .acc_frac    (acc_frac),
    .need        (need),
    .need_next_c (need_next_c)
  );

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    prime_d     = prime_q;
    width_d     = width_q;
    count_d     = count_q;
    out_d       = '{prev: rgb_prev, cur: rgb_cur};
    frac_d      = fraction;
    blank_d     = blank;
    underflow_d = underflow;
    emit        = 1'b0;
    starve      = 1'b0;
    drop        = 1'b0;

    if (line_start) begin
      state_d     = PRIME;
      prime_d     = 1'b0;
      width_d     = out_width;
      count_d     = '0;
      underflow_d = 1'b0;
      blank_d     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: blank_d = 1'b1;
        PRIME: begin
          blank_d = 1'b1;
          if (accept) begin
            prime_d = ~prime_q;
            if (prime_q)
              state_d = (width_q == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (ce_out) begin
            count_d = count_q + WW'(1);
            if (need) begin
              starve  = 1'b1;
              blank_d = 1'b1;
            end else begin
              emit    = 1'b1;
              blank_d = 1'b0;
              frac_d  = acc_frac;
              out_d   = pair_q;
            end
            if (count_d == width_q) begin
              state_d = DONE;
              drop    = 1'b1;
            end
          end
        end
        DONE: begin
          blank_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (starve) underflow_d = 1'b1;
    line_done_d = (state_d == DONE);
  end

  assign in_ready_d = (state_d == PRIME) || ((state_d == RUN) && need_next_c);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prime_q    <= 1'b0;
      width_q    <= '0;
      count_q    <= '0;
      rgb_cur    <= '0;
      rgb_prev   <= '0;
      fraction   <= '0;
      blank      <= 1'b1;
      underflow  <= 1'b0;
      line_done  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prime_q    <= prime_d;
      width_q    <= width_d;
      count_q    <= count_d;
      rgb_cur    <= out_d.cur;
      rgb_prev   <= out_d.prev;
      fraction   <= frac_d;
      blank      <= blank_d;
      underflow  <= underflow_d;
      line_done  <= line_done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Working pair shifts on every accepted source pixel.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      pair_q <= '0;
    else if (accept) begin
      pair_q.prev <= pair_q.cur;
      pair_q.cur  <= src.in_rgb;
    end
  end

  assign src.in_ready = in_ready_q;

`ifdef JTFRAME_INTERP_STATS_EN
  logic [7:0] uf_cnt_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      uf_cnt_q <= 8'h00;
    else if (starve && (uf_cnt_q != 8'hFF))
      uf_cnt_q <= uf_cnt_q + 8'd1;
  end

  assign underflows = uf_cnt_q;
`else
  assign underflows = 8'h00;
`endif

endmodule

// File: tb/tb_interp_phase_ctrl.sv
// Directed self-checking bench for interp_phase_ctrl.
module tb_interp_phase_ctrl;
  import interp_ctrl_pkg::*;

`ifdef JTFRAME_INTERP_STATS_EN
  localparam int UF_ON = 1;
`else
  localparam int UF_ON = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [8:0]  step;
  logic [11:0] out_width;
  logic        ce_out;
  rgb565_t     rgb_cur, rgb_prev;
  logic [7:0]  fraction;
  logic        blank, line_done, underflow;
  logic [7:0]  underflows;

  interp_phase_ctrl_if sif ();

  interp_phase_ctrl #(.FRACW(8), .WW(12)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .line_start (line_start),
    .step       (step),
    .out_width  (out_width),
    .ce_out     (ce_out),
    .src        (sif),
    .rgb_cur    (rgb_cur),
    .rgb_prev   (rgb_prev),
    .fraction   (fraction),
    .blank      (blank),
    .line_done  (line_done),
    .underflow  (underflow),
    .underflows (underflows)
  );

  always #5 clk_sys = ~clk_sys;

  int      errors = 0;
  int      checks = 0;
  int      n_acc  = 0;
  int      n_done = 0;
  int      qi     = 0;
  bit      src_en = 1'b0;
  rgb565_t src[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    sif.in_valid = src_en && (qi < src.size());
    sif.in_rgb   = sif.in_valid ? src[qi] : 16'h0000;
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic clk1();
    bit take;
    take = sif.in_valid && sif.in_ready && !line_start;
    @(posedge clk_sys);
    #1;
    if (take) begin
      n_acc++;
      qi++;
    end
    if (line_done) n_done++;
    line_start = 1'b0;
    ce_out     = 1'b0;
    drive_src();
  endtask

  task automatic start_line(input int st, input int w);
    src_en     = 1'b0;
    drive_src();
    step       = 9'(st);
    out_width  = 12'(w);
    line_start = 1'b1;
    clk1();
    qi     = 0;
    n_acc  = 0;
    src_en = 1'b1;
    drive_src();
  endtask

  task automatic ce(input int gap);
    repeat (gap - 1) clk1();
    ce_out = 1'b1;
    clk1();
  endtask

  task automatic check_pix(input string tag, input logic [7:0] f, input rgb565_t p, input rgb565_t c);
    check({tag, ".blank"}, 32'(blank), 32'd0);
    check({tag, ".frac"},  32'(fraction), 32'(f));
    check({tag, ".prev"},  32'(rgb_prev), 32'(p));
    check({tag, ".cur"},   32'(rgb_cur), 32'(c));
  endtask

  int done0;
  logic [7:0] fr2 [6] = '{8'd0, 8'd128, 8'd0, 8'd128, 8'd0, 8'd128};

  initial begin
    rst_n = 1'b0; line_start = 1'b0; ce_out = 1'b0; step = '0; out_width = '0;
    sif.in_valid = 1'b0; sif.in_rgb = '0;
    #12;
    check("rst.blank", 32'(blank), 32'd1);
    check("rst.cur", 32'(rgb_cur), 32'd0);
    check("rst.prev", 32'(rgb_prev), 32'd0);
    check("rst.ready", 32'(sif.in_ready), 32'd0);
    check("rst.uf", 32'(underflows), 32'd0);
    rst_n = 1'b1;
    clk1(); clk1();

    // Line 1: unity step, one source pixel per output
    src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    done0 = n_done;
    start_line(256, 4);
    check("l1.prime_blank", 32'(blank), 32'd1);
    check("l1.prime_ready", 32'(sif.in_ready), 32'd1);
    clk1(); clk1();
    check("l1.primed_ready", 32'(sif.in_ready), 32'd0);
    check("l1.primed_acc", 32'(n_acc), 32'd2);
    for (int k = 0; k < 4; k++) begin
      ce(4);
      check_pix($sformatf("l1.px%0d", k), 8'd0, src[k], src[k+1]);
    end
    check("l1.line_done", 32'(line_done), 32'd1);
    clk1();
    check("l1.done_pulse", 32'(line_done), 32'd0);
    check("l1.blank_after", 32'(blank), 32'd1);
    check("l1.n_done", 32'(n_done - done0), 32'd1);
    check("l1.n_acc", 32'(n_acc), 32'd5);
    check("l1.underflow", 32'(underflow), 32'd0);

    // Line 2: half step, two outputs per source pixel
    src = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
    done0 = n_done;
    start_line(128, 6);
    clk1(); clk1();
    for (int k = 0; k < 6; k++) begin
      ce(4);
      check_pix($sformatf("l2.px%0d", k), fr2[k], src[k/2], src[k/2+1]);
    end
    clk1(); clk1(); clk1();
    check("l2.n_acc", 32'(n_acc), 32'd4);
    check("l2.n_done", 32'(n_done - done0), 32'd1);

    // Line 3: zero step behaves as unity step
    src = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    start_line(0, 3);
    clk1(); clk1();
    for (int k = 0; k < 3; k++) begin
      ce(4);
      check_pix($sformatf("l3.px%0d", k), 8'd0, src[k], src[k+1]);
    end
    clk1();
    check("l3.n_acc", 32'(n_acc), 32'd4);

    // Line 4: source starves after priming
    src = '{16'hD001, 16'hD002};
    done0 = n_done;
    start_line(256, 4);
    clk1(); clk1();
    ce(2);
    check_pix("l4.px0", 8'd0, 16'hD001, 16'hD002);
    check("l4.uf0", 32'(underflow), 32'd0);
    ce(2);
    check("l4.starve_blank", 32'(blank), 32'd1);
    check("l4.starve_uf", 32'(underflow), 32'd1);
    check("l4.hold_cur", 32'(rgb_cur), 32'hD002);
    ce(2); ce(2);
    check("l4.line_done", 32'(line_done), 32'd1);
    check("l4.underflows", 32'(underflows), 32'(UF_ON * 3));
    clk1();

    // Line 5: zero width completes right after priming
    src = '{16'hE001, 16'hE002};
    start_line(256, 0);
    clk1();
    check("l5.blank", 32'(blank), 32'd1);
    clk1();
    check("l5.line_done", 32'(line_done), 32'd1);
    check("l5.n_acc", 32'(n_acc), 32'd2);
    clk1();
    check("l5.done_pulse", 32'(line_done), 32'd0);

    // Line 6: abort a starved line with line_start
    src = '{16'hF001, 16'hF002};
    start_line(256, 8);
    clk1(); clk1();
    ce(2); ce(2);
    check("l6.uf_set", 32'(underflow), 32'd1);
    done0 = n_done;
    src = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
    start_line(256, 2);
    check("l6.uf_clr", 32'(underflow), 32'd0);
    check("l6.blank", 32'(blank), 32'd1);
    check("l6.ready", 32'(sif.in_ready), 32'd1);
    ce_out = 1'b1;
    clk1();
    check("l6.prime_ce_blank", 32'(blank), 32'd1);
    clk1();
    check("l6.primed_blank", 32'(blank), 32'd1);
    ce(2);
    check_pix("l6.px0", 8'd0, 16'hB001, 16'hB002);
    ce(2);
    check_pix("l6.px1", 8'd0, 16'hB002, 16'hB003);
    clk1();
    check("l6.n_done", 32'(n_done - done0), 32'd1);
    check("l6.underflows", 32'(underflows), 32'(UF_ON * 4));

    // Line 7: asynchronous reset in the middle of RUN
    src = '{16'h9001, 16'h9002, 16'h9003, 16'h9004, 16'h9005};
    start_line(128, 6);
    clk1(); clk1();
    ce(2); ce(2);
    check_pix("l7.px1", 8'd128, 16'h9001, 16'h9002);
    #3 rst_n = 1'b0;
    #1;
    check("l7.rst_blank", 32'(blank), 32'd1);
    check("l7.rst_cur", 32'(rgb_cur), 32'd0);
    check("l7.rst_prev", 32'(rgb_prev), 32'd0);
    check("l7.rst_frac", 32'(fraction), 32'd0);
    check("l7.rst_ready", 32'(sif.in_ready), 32'd0);
    check("l7.rst_uf", 32'(underflows), 32'd0);
    #2 rst_n = 1'b1;
    done0 = n_done;
    n_acc = 0;
    clk1(); clk1(); clk1();
    check("l7.idle_ready", 32'(sif.in_ready), 32'd0);
    check("l7.idle_blank", 32'(blank), 32'd1);
    check("l7.idle_acc", 32'(n_acc), 32'd0);
    check("l7.idle_done", 32'(n_done - done0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
